regfile_dump: RTL and testbench



---
 rtl/regfile_dump_pkg.sv | 10 +
 rtl/regfile_dump_word_chunker.sv | 40 ++++
 rtl/regfile_dump.sv | 79 +++++++
 tb/tb_regfile_dump.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared state type and constants for the register dump engine
package regfile_dump_pkg;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;
  localparam int DEF_OUT_W = 8;
  localparam int CHUNKS = 32 / DEF_OUT_W;
  localparam logic [3:0] PC_IDX = 4'd15;
  function automatic int chunks_of(input int out_w);
    return 32 / out_w;
  endfunction
endpackage

// File: rtl/regfile_dump_word_chunker.sv
// word_chunker: holds one captured register and streams it out as little-endian chunks
module word_chunker
  import regfile_dump_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             send,
  input  logic             out_ready,
  input  logic [31:0]      word_in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             fire,
  output logic             last_chunk
);
  localparam logic [1:0] LAST = 2'(chunks_of(OUT_W) - 1);
  logic [31:0] hold_q, hold_d;
  logic [1:0]  byte_q, byte_d;
  // chunk select, handshake and next holding/byte values; a load always restarts at chunk 0
  always_comb begin
    out_valid  = send;
    fire       = send && out_ready;
    last_chunk = byte_q == LAST;
    out_data   = OUT_W'(hold_q >> (OUT_W * int'(byte_q)));
    hold_d     = load ? word_in : hold_q;
    byte_d     = load ? 2'd0 : (fire && !last_chunk) ? byte_q + 2'd1 : byte_q;
  end
  // holding register and byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      byte_q <= '0;
    end else begin
      hold_q <= hold_d;
      byte_q <= byte_d;
    end
  end
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks the regfile debug read port and streams every register out
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ra,
  input  logic [31:0]      rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             out_last
);
  localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);
  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d, ra_q, ra_d;
  logic       load, send, fire, last_chunk;
  // state, register index and read address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ra_q    <= ra_d;
    end
  end
  // next state; ra follows the index so rd is ready during the single READ cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ra_d    = ra_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        idx_d   = '0;
        ra_d    = '0;
      end
      READ: state_d = SEND;
      SEND: if (fire && last_chunk) begin
        state_d = (idx_q == LAST_IDX) ? DONE : READ;
        idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 4'd1;
        ra_d    = (idx_q == LAST_IDX) ? ra_q : idx_q + 4'd1;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // Moore outputs decoded from the current state
  always_comb begin
    busy     = state_q == READ || state_q == SEND;
    done     = state_q == DONE;
    load     = state_q == READ;
    send     = state_q == SEND;
    ra       = ra_q;
    out_idx  = idx_q;
    out_last = send && idx_q == LAST_IDX && last_chunk;
  end
  word_chunker #(.OUT_W(OUT_W)) u_chunker (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .send       (send),
    .out_ready  (out_ready),
    .word_in    (rd),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fire       (fire),
    .last_chunk (last_chunk)
  );
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized and directed checks of the dump engine against a stream model
module tb_regfile_dump;
  typedef struct packed {logic [3:0] idx; logic [31:0] data; logic last;} chunk_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, start_a = 0, start_b = 0, out_ready_a = 0, out_ready_b = 0;
  logic busy_a, done_a, out_valid_a, out_last_a, busy_b, done_b, out_valid_b, out_last_b;
  logic [3:0] ra_a, out_idx_a, ra_b, out_idx_b;
  logic [31:0] rd_a, rd_b, out_data_b;
  logic [7:0] out_data_a;
  logic [31:0] regs_a [16];
  logic [31:0] regs_b [16];
  assign rd_a = regs_a[ra_a];
  assign rd_b = regs_b[ra_b];
  regfile_dump #(.NREGS(16), .OUT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .ra(ra_a), .rd(rd_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a));
  regfile_dump #(.NREGS(4), .OUT_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .ra(ra_b), .rd(rd_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b));
  chunk_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int passed = 0, total = 0, done_a_cnt = 0, done_b_cnt = 0;
  logic stall_q = 0;
  logic [11:0] held_q = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) got_a.push_back(chunk_t'{out_idx_a, 32'(out_data_a), out_last_a});
    if (out_valid_b && out_ready_b) got_b.push_back(chunk_t'{out_idx_b, out_data_b, out_last_b});
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if (stall_q && out_valid_a) check("hold_stable", {out_idx_a, out_data_a}, held_q);
    stall_q <= out_valid_a && !out_ready_a && !reset;
    held_q  <= {out_idx_a, out_data_a};
  end
  task automatic build_a(input logic [31:0] m [16]);
    exp_a.delete();
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++)
        exp_a.push_back(chunk_t'{4'(i), (m[i] >> (8 * k)) & 32'hff, i == 15 && k == 3});
  endtask
  task automatic build_b(input logic [31:0] m [16]);
    exp_b.delete();
    for (int i = 0; i < 4; i++) exp_b.push_back(chunk_t'{4'(i), m[i], i == 3});
  endtask
  task automatic compare_a();
    check("a_count", got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) check("a_chunk", got_a[i], exp_a[i]);
  endtask
  task automatic compare_b();
    check("b_count", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) check("b_chunk", got_b[i], exp_b[i]);
  endtask
  task automatic run_dump(input bit b, input int mode, input int extra_at, input bit wr, output int cycles);
    bit written = 0;
    logic rdy;
    @(posedge clk); #1;
    if (b) begin start_b = 1; out_ready_b = 1; end else begin start_a = 1; out_ready_a = 1; end
    @(posedge clk); #1;
    cycles = 0;
    while (!(b ? done_b : done_a) && cycles < 2000) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cycles % 4 == 0 || cycles % 4 == 3) : ($urandom_range(0, 2) != 0);
      if (b) begin start_b = (cycles == extra_at); out_ready_b = rdy; end
      else begin start_a = (cycles == extra_at); out_ready_a = rdy; end
      if (wr && !written && out_valid_a && out_idx_a == 4'd1) begin
        regs_a[2] = 32'hDEAD_BEEF;
        regs_a[0] = 32'h1234_5678;
        written = 1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start_a = 0;
    start_b = 0;
    check("timeout", cycles < 2000, 1);
    check("done_busy", b ? busy_b : busy_a, 0);
    check("done_valid", b ? out_valid_b : out_valid_a, 0);
    @(posedge clk); #1;
    check("idle_done", b ? done_b : done_a, 0);
    check("idle_busy", b ? busy_b : busy_a, 0);
  endtask
  initial begin
    int cyc, d0, n;
    logic [31:0] m [16];
    for (int i = 0; i < 16; i++) begin
      regs_a[i] = i == 15 ? 32'h0000_0100 : 32'(32'h1111_1111 * i);
      regs_b[i] = '0;
    end
    regs_b[0] = 32'hA0; regs_b[1] = 32'hB1; regs_b[2] = 32'hC2; regs_b[3] = 32'hD3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_valid", out_valid_a, 0);
    check("rst_last", out_last_a, 0);
    check("rst_ra", ra_a, 0);
    check("rst_idx", out_idx_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_b_data", out_data_b, 0);
    reset = 0;
    // basic byte dump, ready held high
    got_a.delete(); d0 = done_a_cnt; build_a(regs_a);
    run_dump(0, 0, -1, 0, cyc);
    check("t1_cycles", cyc, 80);
    check("t1_done_cnt", done_a_cnt - d0, 1);
    compare_a();
    // backpressure 1,0,0,1
    got_a.delete(); d0 = done_a_cnt;
    run_dump(0, 1, -1, 0, cyc);
    check("t2_done_cnt", done_a_cnt - d0, 1);
    compare_a();
    // word-wide four-register dump
    got_b.delete(); d0 = done_b_cnt; build_b(regs_b);
    run_dump(1, 0, -1, 0, cyc);
    check("t3_cycles", cyc, 8);
    check("t3_done_cnt", done_b_cnt - d0, 1);
    compare_b();
    // extra start mid-dump is ignored, then a fresh dump works
    got_a.delete(); d0 = done_a_cnt;
    run_dump(0, 0, 20, 0, cyc);
    check("t4_cycles", cyc, 80);
    check("t4_done_cnt", done_a_cnt - d0, 1);
    compare_a();
    got_a.delete();
    run_dump(0, 0, -1, 0, cyc);
    compare_a();
    // reset during SEND of register 5
    @(posedge clk); #1;
    start_a = 1; out_ready_a = 1;
    @(posedge clk); #1;
    start_a = 0; n = 0;
    while (!(out_valid_a && out_idx_a == 4'd5) && n < 500) begin @(posedge clk); #1; n++; end
    check("t5_reach", n < 500, 1);
    d0 = done_a_cnt; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("t5_valid", out_valid_a, 0);
    check("t5_busy", busy_a, 0);
    check("t5_ra", ra_a, 0);
    check("t5_done", done_a, 0);
    check("t5_idx", out_idx_a, 0);
    check("t5_last", out_last_a, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_a_cnt - d0, 0);
    got_a.delete();
    run_dump(0, 0, -1, 0, cyc);
    compare_a();
    // writes while register 1 is being sent
    m = regs_a; m[2] = 32'hDEAD_BEEF; build_a(m);
    got_a.delete();
    run_dump(0, 0, -1, 1, cyc);
    compare_a();
    // randomized contents and ready
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin regs_a[i] = $urandom; regs_b[i] = $urandom; end
      build_a(regs_a); got_a.delete();
      run_dump(0, 2, -1, 0, cyc);
      compare_a();
      build_b(regs_b); got_b.delete();
      run_dump(1, 2, -1, 0, cyc);
      compare_b();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
